// File: rtl/lfsr_cipher_pkg.sv
// Shared definitions for the LFSR stream cipher: FSM state encoding and default feedback taps.
package lfsr_cipher_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGen  = 2'd1,
        StRdy  = 2'd2
    } state_e;

    localparam logic [7:0] TAPS_DEFAULT = 8'hB8;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load, all-zero lockup guard and tap-mask feedback.
module lfsr_core #(
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(8'hB8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              shift,
    output logic [DATA_W-1:0] state
);

    logic fb;

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            // An all-zero register would never leave zero, so substitute 1.
            state <= (seed == '0) ? DATA_W'(1) : seed;
        end else if (shift) begin
            state <= {state[DATA_W-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_cipher_stream.sv
// LFSR keystream cipher: generates a KEY_W-bit key per word and XORs it into each plaintext word.
// Optional 16-bit accepted-word counter enabled by defining LFSR_CIPHER_WORDCNT_EN.
module lfsr_cipher_stream
    import lfsr_cipher_pkg::*;
#(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       KEY_W  = 6,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(TAPS_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic [KEY_W-1:0]  key,
    output logic              ready
`ifdef LFSR_CIPHER_WORDCNT_EN
    ,
    output logic [15:0]       word_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] lfsr;
    logic              shift;
    logic              accept;

    assign shift    = (state == StGen) && !load;
    assign ready    = (state == StRdy);
    assign key      = ready ? KEY_W'(lfsr) : '0;
    assign in_ready = ready && !load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    lfsr_core #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .seed  (seed),
        .shift (shift),
        .state (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            // The output register is independent of load so a pending word survives a reseed.
            if (accept) begin
                dout      <= din ^ DATA_W'(key);
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (load) begin
                state <= StGen;
                cnt   <= '0;
            end else begin
                case (state)
                    StGen: begin
                        if (cnt == CNT_W'(KEY_W - 1)) begin
                            state <= StRdy;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    StRdy: begin
                        if (accept) begin
                            state <= StGen;
                            cnt   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LFSR_CIPHER_WORDCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (load) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_cipher_stream.sv
// Directed self-checking bench for lfsr_cipher_stream with hand-computed LFSR/key/cipher values.
module tb_lfsr_cipher_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] seed;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;
    logic [5:0] key;
    logic       ready;
`ifdef LFSR_CIPHER_WORDCNT_EN
    logic [15:0] word_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_cipher_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .key       (key),
        .ready     (ready)
`ifdef LFSR_CIPHER_WORDCNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises; 20 means it never did.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
    endtask

    logic [7:0] seq [6] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    int n;

    initial begin
        rst_n = 1'b0; load = 1'b0; seed = 8'h00;
        in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
        step(); step();
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_key", 32'(key), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_lfsr", 32'(dut.lfsr), 0);

        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        step(); step();
        check_eq("idle_ready", 32'(ready), 0);
        check_eq("idle_in_ready", 32'(in_ready), 0);
        check_eq("idle_lfsr", 32'(dut.lfsr), 0);
        in_valid = 1'b0;

        // Key generation from seed 01
        seed = 8'h01; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("kg_seed", 32'(dut.lfsr), 32'h01);
        for (int i = 0; i < 6; i++) begin
            check_eq("kg_ready_low", 32'(ready), 0);
            check_eq("kg_in_ready_low", 32'(in_ready), 0);
            step();
            check_eq($sformatf("kg_lfsr%0d", i), 32'(dut.lfsr), 32'(seq[i]));
        end
        check_eq("kg_ready", 32'(ready), 1);
        check_eq("kg_key", 32'(key), 32'h07);

        // Encryption: 00 ^ 07, then FF ^ 04
        din = 8'h00; in_valid = 1'b1;
        #1;
        check_eq("enc_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check_eq("enc0_valid", 32'(out_valid), 1);
        check_eq("enc0_dout", 32'(dout), 32'h07);
        check_eq("enc0_ready_low", 32'(ready), 0);
        wait_ready(n);
        check_eq("enc_gap", 32'(n), 6);
        check_eq("enc_valid_drained", 32'(out_valid), 0);
        check_eq("enc_key2", 32'(key), 32'h04);
        check_eq("enc_lfsr2", 32'(dut.lfsr), 32'hC4);
        din = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("enc1_dout", 32'(dout), 32'hFB);
`ifdef LFSR_CIPHER_WORDCNT_EN
        check_eq("wc_two", 32'(word_cnt), 2);
`endif

        // Back-pressure: out_ready low while the next key becomes ready
        wait_ready(n);
        check_eq("bp_gap", 32'(n), 6);
        check_eq("bp_key", 32'(key), 32'h2E);
        din = 8'h55; in_valid = 1'b1;
        #1;
        check_eq("bp_in_ready_low", 32'(in_ready), 0);
        step(); step();
        check_eq("bp_dout_hold", 32'(dout), 32'hFB);
        check_eq("bp_valid_hold", 32'(out_valid), 1);
        check_eq("bp_still_ready", 32'(ready), 1);
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_high", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check_eq("bp_dout_new", 32'(dout), 32'h7B);
        check_eq("bp_valid_new", 32'(out_valid), 1);
`ifdef LFSR_CIPHER_WORDCNT_EN
        check_eq("wc_three", 32'(word_cnt), 3);
`endif
        step();
        check_eq("bp_valid_clear", 32'(out_valid), 0);

        // Lockup guard: zero seed behaves as seed 01
        seed = 8'h00; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("lk_lfsr", 32'(dut.lfsr), 32'h01);
`ifdef LFSR_CIPHER_WORDCNT_EN
        check_eq("wc_clear", 32'(word_cnt), 0);
`endif
        wait_ready(n);
        check_eq("lk_gap", 32'(n), 6);
        check_eq("lk_lfsr_end", 32'(dut.lfsr), 32'h47);
        check_eq("lk_key", 32'(key), 32'h07);

        // Mid-GEN reload with a pending output word
        out_ready = 1'b0; din = 8'h10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("mg_dout", 32'(dout), 32'h17);
        step(); step(); step();
        check_eq("mg_lfsr3", 32'(dut.lfsr), 32'h38);
        seed = 8'h01; load = 1'b1; in_valid = 1'b1; din = 8'hAA;
        step();
        load = 1'b0; in_valid = 1'b0;
        check_eq("mg_reseed", 32'(dut.lfsr), 32'h01);
        check_eq("mg_pending_valid", 32'(out_valid), 1);
        check_eq("mg_pending_dout", 32'(dout), 32'h17);
        wait_ready(n);
        check_eq("mg_gap", 32'(n), 6);
        check_eq("mg_key", 32'(key), 32'h07);

        // Load colliding with an acceptable word in RDY
        out_ready = 1'b1; load = 1'b1; seed = 8'h01; in_valid = 1'b1; din = 8'hAA;
        #1;
        check_eq("col_in_ready", 32'(in_ready), 0);
        step();
        load = 1'b0; in_valid = 1'b0;
        check_eq("col_valid", 32'(out_valid), 0);
        check_eq("col_dout", 32'(dout), 32'h17);
        check_eq("col_ready", 32'(ready), 0);
        wait_ready(n);
        check_eq("col_gap", 32'(n), 6);

        // Reset in RDY with out_valid high; rst_n beats load
        out_ready = 1'b0; din = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_ready(n);
        check_eq("rs_pre_key", 32'(key), 32'h04);
        check_eq("rs_pre_valid", 32'(out_valid), 1);
        rst_n = 1'b0; load = 1'b1; seed = 8'h01;
        step();
        rst_n = 1'b1; load = 1'b0;
        check_eq("rs_valid", 32'(out_valid), 0);
        check_eq("rs_dout", 32'(dout), 0);
        check_eq("rs_key", 32'(key), 0);
        check_eq("rs_ready", 32'(ready), 0);
        check_eq("rs_lfsr", 32'(dut.lfsr), 0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("rs_idle_ready", 32'(ready), 0);
        check_eq("rs_idle_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_ready(n);
        check_eq("rs_reload_gap", 32'(n), 6);
        check_eq("rs_reload_key", 32'(key), 32'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
